// File: rtl/seq_mult16.sv
// -----------------------------------------------------------------------------
// seq_mult16
//   Multi-cycle unsigned shift-add multiplier, 16x16 -> 32, for the LEGv8 MUL
//   path. One Sixteen_Bit_Adder is shared across all iterations. Each RUN
//   cycle adds (mq[0] ? mc : 0) to the upper partial product. The 17-bit
//   {c_out, sum} result then shifts right by one into {acc, mq}.
//
// Ports
//   clk      in   1   single clock, rising edge
//   rst      in   1   synchronous, active-high reset
//   start    in   1   request, sampled only in IDLE
//   mcand    in  16   multiplicand, latched on the accepting edge
//   mplier   in  16   multiplier, latched on the accepting edge
//   busy     out  1   high while an operation is iterating
//   done     out  1   one-cycle pulse, product valid from this cycle on
//   product  out 32   registered unsigned result, held until the next result
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// Sixteen_Bit_Adder
//   The existing 16-bit ripple adder of the datapath, reproduced here so the
//   multiplier is self-contained.
//
// Ports
//   a, b   in  16   addends
//   c_in   in   1   carry in
//   sum    out 16   a + b + c_in, low 16 bits
//   c_out  out  1   carry out
// -----------------------------------------------------------------------------
module Sixteen_Bit_Adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {16'h0000, c_in};
endmodule

module seq_mult16 #(
    parameter int WIDTH = 16,
    parameter int ITERS = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // The shared adder is fixed at 16 bits, so no other width can work.
    if (WIDTH != 16 || ITERS != WIDTH) begin : g_bad_params
        $error("seq_mult16: WIDTH must be 16 and ITERS must equal WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mc;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [4:0]         count;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [2*WIDTH-1:0] next_pp;

    assign add_b = mq[0] ? mc : '0;

    Sixteen_Bit_Adder u_adder (
        .a     (acc),
        .b     (add_b),
        .c_in  (1'b0),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    // The carry becomes the new MSB of the partial product. Dropping it
    // corrupts results whose partial sums overflow 16 bits (e.g. FFFF x FFFF).
    assign next_pp = {add_cout, add_sum, mq[WIDTH-1:1]};

    // NOTE: every register here is written with non-blocking assignments, so
    // each one in the block samples the pre-edge value of the others. acc and
    // mq can then shift from one another with no ordering hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the whole datapath is cleared, not only the control state,
            // so an aborted operation leaves no trace in acc/mq/mc/product.
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            count   <= '0;
            acc     <= '0;
            mq      <= '0;
            mc      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mc    <= mcand;
                        mq    <= mplier;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end

                S_RUN: begin
                    {acc, mq} <= next_pp;
                    count     <= count + 5'd1;
                    // The final iteration writes its own post-shift value straight to product.
                    if (count == 5'(ITERS - 1)) begin
                        product <= next_pp;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult16.sv
// -----------------------------------------------------------------------------
// tb_seq_mult16
//   Directed and randomized stimulus for seq_mult16. Each expected product
//   comes from plain 32-bit multiplication of the operands the bench applied.
//   Timing expectations are the handshake figures: busy for 16 cycles, done on
//   the 17th cycle after accept, and 18-cycle spacing with start held high.
//   Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_mult16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int checks   = 0;
    int failures = 0;

    // Product the DUT should currently be holding.
    logic [31:0] held_product;

    seq_mult16 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_mul(input logic [15:0] a, input logic [15:0] b);
        return 32'(a) * 32'(b);
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One complete operation from an idle DUT. With spam set, start is pulsed
    // with operands 7 and 9 while the operation runs, and must be ignored.
    // Otherwise the operands are scrambled after accept to prove they were latched.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input bit spam);
        logic [31:0] exp_p = model_mul(a, b);
        int          n     = 0;
        bit          got   = 1'b0;
        mcand  = a;
        mplier = b;
        start  = 1'b1;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (spam && n <= 14) begin
                start  = 1'b1;
                mcand  = 16'd7;
                mplier = 16'd9;
            end else begin
                start  = 1'b0;
                mcand  = 16'($urandom);
                mplier = 16'($urandom);
            end
            if (done) begin
                got = 1'b1;
            end else if (n <= 16) begin
                check({tag, " busy"}, 32'(busy), 32'd1);
                check({tag, " hold"}, product, held_product);
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(n), 32'd17);
        check({tag, " product"}, product, exp_p);
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        held_product = exp_p;
        @(negedge clk);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " product_after"}, product, held_product);
    endtask

    initial begin
        int          timer;
        int          dones;
        int          last_done;
        logic [15:0] qa[$];
        logic [15:0] qb[$];
        logic [15:0] na;
        logic [15:0] nb;

        rst    = 1'b1;
        start  = 1'b0;
        mcand  = 16'h0;
        mplier = 16'h0;
        held_product = 32'h0;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset product", product, 32'h0);
        repeat (5) @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);
        check("idle done", 32'(done), 32'd0);
        check("idle product", product, 32'h0);

        // Basic operation, then a long idle stretch.
        run_op("3x5", 16'd3, 16'd5, 1'b0);
        repeat (20) @(negedge clk);
        check("3x5 idle hold", product, held_product);
        check("3x5 idle done", 32'(done), 32'd0);

        // Boundary operands.
        run_op("ffff_sq", 16'hFFFF, 16'hFFFF, 1'b0);
        run_op("8000x2", 16'h8000, 16'h0002, 1'b0);
        run_op("0x1234", 16'h0000, 16'h1234, 1'b0);
        run_op("1234x0", 16'h1234, 16'h0000, 1'b0);

        // start asserted during RUN must be ignored.
        run_op("spam 3x5", 16'd3, 16'd5, 1'b1);
        repeat (3) @(negedge clk);
        check("spam no_accept busy", 32'(busy), 32'd0);
        check("spam no_accept done", 32'(done), 32'd0);
        check("spam product", product, held_product);

        // Reset in the middle of an operation.
        mcand  = 16'h1234;
        mplier = 16'h5678;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        held_product = 32'h0;
        check("midrun rst busy", 32'(busy), 32'd0);
        check("midrun rst done", 32'(done), 32'd0);
        check("midrun rst product", product, 32'h0);
        run_op("1234x5678", 16'h1234, 16'h5678, 1'b0);

        // Random ops via the same handshake.
        for (int i = 0; i < 8; i++) begin
            run_op("rand", 16'($urandom), 16'($urandom), 1'b0);
        end

        // start held high: new operands are presented at each done. Even-numbered
        // operations square a random value; odd-numbered ones use a random pair.
        dones     = 0;
        last_done = 0;
        timer     = 0;
        na = 16'($urandom);
        qa.push_back(na);
        qb.push_back(na);
        mcand  = na;
        mplier = na;
        start  = 1'b1;
        while (dones < 100 && timer < 100 * 18 + 60) begin
            @(negedge clk);
            timer++;
            if (done) begin
                check("b2b product", product, model_mul(qa.pop_front(), qb.pop_front()));
                if (dones > 0) begin
                    check("b2b spacing", 32'(timer - last_done), 32'd18);
                end
                last_done = timer;
                dones++;
                if (dones < 100) begin
                    na = 16'($urandom);
                    nb = dones[0] ? 16'($urandom) : na;
                    qa.push_back(na);
                    qb.push_back(nb);
                    mcand  = na;
                    mplier = nb;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b done_count", 32'(dones), 32'd100);
        repeat (3) @(negedge clk);
        check("b2b final busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
